// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and entry layout for the store controller
package mem_pkg;

   localparam int DEPTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } st_entry_t;

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - synchronous FIFO holding steered store entries
module store_fifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // A pop in the same cycle does not free a slot for the push.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_store_ctrl.sv
// rtl/mem_store_ctrl.sv - store queue with lane steering and RAM write handshake
module mem_store_ctrl
   import mem_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [1:0]  st_size,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        busy,
   output logic        err_align
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_e            state_q, state_d;
   logic              err_align_q, err_align_d;
   st_entry_t         push_entry, head_entry;
   logic              misaligned, accept, push, pop;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;

   always_comb begin
      misaligned = 1'b0;
      case (size_e'(st_size))
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = st_addr[0];
         SZ_WORD: misaligned = |st_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   always_comb begin
      push_entry       = '0;
      push_entry.addr  = {st_addr[31:2], 2'b00};
      case (size_e'(st_size))
         SZ_BYTE: begin
            push_entry.wdata = {4{st_data[7:0]}};
            push_entry.be    = 4'b0001 << st_addr[1:0];
         end
         SZ_HALF: begin
            push_entry.wdata = {2{st_data[15:0]}};
            push_entry.be    = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         SZ_WORD: begin
            push_entry.wdata = st_data;
            push_entry.be    = 4'b1111;
         end
         default: begin
            push_entry.wdata = '0;
            push_entry.be    = '0;
         end
      endcase
   end

   assign st_ready    = !fifo_full;
   assign accept      = st_valid && st_ready;
   assign push        = accept && !misaligned;
   assign err_align_d = accept && misaligned;
   assign err_align   = err_align_q;
   assign busy        = !fifo_empty || mem_req;

   store_fifo #(
      .WIDTH ($bits(st_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      pop       = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_REQ;
         end
         ST_REQ: begin
            mem_req   = 1'b1;
            mem_addr  = head_entry.addr;
            mem_wdata = head_entry.wdata;
            mem_be    = head_entry.be;
            // A concurrent push keeps the queue non-empty after the last pop.
            if (mem_ack) begin
               pop = 1'b1;
               if (fifo_count == CW'(1) && !push) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         err_align_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_align_q <= err_align_d;
      end
   end

endmodule

// File: tb/tb_mem_store_ctrl.sv
// tb/tb_mem_store_ctrl.sv - scoreboard bench for mem_store_ctrl
module tb_mem_store_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic [1:0]  st_size = '0;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        busy;
   logic        err_align;

   logic        ack_force = 1'b0;
   logic        ack_rand = 1'b0;
   logic        ack_rnd_bit = 1'b0;

   int          n_checks = 0;
   int          n_fail = 0;
   int          err_pend = 0;
   int          writes = 0;
   int          req_cycles = 0;
   logic [67:0] exp_q[$];

   assign mem_ack = ack_rand ? ack_rnd_bit : ack_force;

   mem_store_ctrl #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_size   (st_size),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .busy      (busy),
      .err_align (err_align)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 ack_rnd_bit = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit model_legal(input logic [31:0] a, input logic [1:0] s);
      if (s == 2'd3) return 1'b0;
      if (s == 2'd1) return (a % 2) == 0;
      if (s == 2'd2) return (a % 4) == 0;
      return 1'b1;
   endfunction

   function automatic logic [67:0] model_entry(input logic [31:0] a, input logic [31:0] d,
                                               input logic [1:0] s);
      logic [31:0] w;
      logic [3:0]  b;
      case (s)
         2'd0: begin
            w = {24'd0, d[7:0]} * 32'h0101_0101;
            b = 4'(1 << (a % 4));
         end
         2'd1: begin
            w = {16'd0, d[15:0]} * 32'h0001_0001;
            b = ((a % 4) >= 2) ? 4'hC : 4'h3;
         end
         default: begin
            w = d;
            b = 4'hF;
         end
      endcase
      return {a - (a % 4), w, b};
   endfunction

   // Monitor: model queue depth mirrors DUT occupancy at each falling edge.
   always @(negedge clk) begin
      if (reset_n) begin
         chk("st_ready", 68'(st_ready), 68'(exp_q.size() < DEPTH));
         chk("busy", 68'(busy), 68'(exp_q.size() != 0));
         chk("err_align", 68'(err_align), 68'(err_pend != 0));
         err_pend = 0;
         if (!mem_req) chk("idle_zero", {mem_addr, mem_wdata, mem_be}, 68'd0);
         if (mem_req) req_cycles++;
         if (mem_req && mem_ack) begin
            writes++;
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {mem_addr, mem_wdata, mem_be}, 68'd0);
            end else begin
               chk("write", {mem_addr, mem_wdata, mem_be}, exp_q.pop_front());
            end
         end
      end
   end

   task automatic model_accept(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      if (model_legal(a, s)) exp_q.push_back(model_entry(a, d, s));
      else err_pend++;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      int n = 0;
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_size  = s;
      @(negedge clk);
      while (!st_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!st_ready) begin
         chk("send_timeout", 68'(st_ready), 68'd1);
      end else begin
         @(posedge clk);
         model_accept(a, d, s);
      end
      #1 st_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      ack_rand  = 1'b0;
      ack_force = 1'b1;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1 chk("drain_empty", 68'(exp_q.size()), 68'd0);
   endtask

   initial begin
      int          r0;
      logic [31:0] a, d;
      logic [1:0]  s;
      logic [67:0] e;

      #3;
      chk("rst_st_ready", 68'(st_ready), 68'd1);
      chk("rst_mem_req", 68'(mem_req), 68'd0);
      chk("rst_busy", 68'(busy), 68'd0);
      chk("rst_err", 68'(err_align), 68'd0);
      chk("rst_mem_out", {mem_addr, mem_wdata, mem_be}, 68'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // word store, ack tied high, with latency check
      ack_force = 1'b1;
      r0 = req_cycles;
      send(32'h100, 32'hDEAD_BEEF, 2'd2);
      chk("lat_idle", 68'(mem_req), 68'd0);
      @(posedge clk); #1;
      chk("lat_req", 68'(mem_req), 68'd1);
      chk("word_out", {mem_addr, mem_wdata, mem_be}, {32'h100, 32'hDEAD_BEEF, 4'hF});
      @(posedge clk); #1;
      chk("word_done", 68'(mem_req), 68'd0);
      chk("word_req_cycles", 68'(req_cycles - r0), 68'd1);

      // byte store
      send(32'h203, 32'h0000_00A5, 2'd0);
      @(posedge clk); #1;
      chk("byte_out", {mem_addr, mem_wdata, mem_be}, {32'h200, 32'hA5A5_A5A5, 4'h8});
      repeat (2) @(posedge clk); #1;

      // misaligned halfword
      r0 = req_cycles;
      send(32'h101, 32'h1234, 2'd1);
      chk("mis_err", 68'(err_align), 68'd1);
      chk("mis_busy", 68'(busy), 68'd0);
      @(posedge clk); #1;
      chk("mis_err_off", 68'(err_align), 68'd0);
      chk("mis_busy2", 68'(busy), 68'd0);
      repeat (2) @(posedge clk); #1;
      chk("mis_no_req", 68'(req_cycles - r0), 68'd0);

      // backpressure
      ack_force = 1'b0;
      for (int i = 0; i < 4; i++) send(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 2'd2);
      chk("bp_full", 68'(st_ready), 68'd0);
      st_valid = 1'b1;
      st_addr  = 32'h1010;
      st_data  = 32'hA000_0004;
      st_size  = 2'd2;
      repeat (3) begin
         @(negedge clk);
         chk("bp_stalled", 68'(st_ready), 68'd0);
      end
      ack_force = 1'b1;
      r0 = 0;
      @(negedge clk);
      while (!st_ready && r0 < 20) begin
         r0++;
         @(negedge clk);
      end
      chk("bp_5th_ready", 68'(st_ready), 68'd1);
      @(posedge clk);
      if (st_ready) model_accept(32'h1010, 32'hA000_0004, 2'd2);
      #1 st_valid = 1'b0;
      drain();

      // stall stability
      ack_force = 1'b0;
      d = $urandom;
      e = model_entry(32'h400, d, 2'd2);
      send(32'h400, d, 2'd2);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         chk("stall_hold", {mem_addr, mem_wdata, mem_be}, e);
         @(posedge clk); #1;
      end
      drain();

      // reset during a pending handshake
      ack_force = 1'b0;
      send(32'h800, 32'h1111_1111, 2'd2);
      send(32'h804, 32'h2222_2222, 2'd2);
      @(posedge clk); #1;
      chk("rst_mid_req", 68'(mem_req), 68'd1);
      @(negedge clk); #2;
      reset_n = 1'b0;
      exp_q.delete();
      err_pend = 0;
      #1;
      chk("rst_mid_req0", 68'(mem_req), 68'd0);
      chk("rst_mid_out0", {mem_addr, mem_wdata, mem_be}, 68'd0);
      chk("rst_mid_busy0", 68'(busy), 68'd0);
      chk("rst_mid_ready", 68'(st_ready), 68'd1);
      chk("rst_mid_err0", 68'(err_align), 68'd0);
      ack_force = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      r0 = writes;
      repeat (5) @(posedge clk); #1;
      chk("rst_no_write", 68'(writes - r0), 68'd0);

      // randomized traffic with random ack
      ack_rand = 1'b1;
      for (int i = 0; i < 80; i++) begin
         s = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (s == 2'd1) a[0] = 1'b0;
            if (s == 2'd2) a[1:0] = 2'b00;
         end
         d = $urandom;
         send(a, d, s);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
